// File: rtl/rv32i_regfile_write_arbiter.sv
// Shares the single register-file write port between two writeback requesters.
// Each requester has a one-entry buffer, and a round-robin pointer picks which buffer drains.
module rv32i_regfile_write_arbiter #(
  parameter int NUM_OF_SETS    = 32,
  parameter int DATA_BUS_WIDTH = 32,
  localparam int AW            = $clog2(NUM_OF_SETS)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      req0_valid,
  input  logic [AW-1:0]             req0_addr,
  input  logic [DATA_BUS_WIDTH-1:0] req0_data,
  output logic                      req0_ready,
  input  logic                      req1_valid,
  input  logic [AW-1:0]             req1_addr,
  input  logic [DATA_BUS_WIDTH-1:0] req1_data,
  output logic                      req1_ready,
  output logic                      rf_wr_enable,
  output logic [AW-1:0]             rf_wr_addr,
  output logic [DATA_BUS_WIDTH-1:0] rf_wr_data,
  output logic [NUM_OF_SETS-1:0]    pend_mask
);

  logic                      buf0_full_r, buf1_full_r;
  logic [AW-1:0]             buf0_addr_r, buf1_addr_r;
  logic [DATA_BUS_WIDTH-1:0] buf0_data_r, buf1_data_r;
  logic                      prio_r;
  logic                      grant0_s, grant1_s;
  logic                      acc0_s, acc1_s;

  function automatic logic [NUM_OF_SETS-1:0] onehot(input logic [AW-1:0] idx);
    logic [NUM_OF_SETS-1:0] v;
    v      = {NUM_OF_SETS{1'b0}};
    v[idx] = 1'b1;
    return v;
  endfunction

  // Grant decision from buffer occupancy and the round-robin pointer only
  always_comb begin
    grant0_s = 1'b0;
    grant1_s = 1'b0;
    case ({buf1_full_r, buf0_full_r})
      2'b01:   grant0_s = 1'b1;
      2'b10:   grant1_s = 1'b1;
      2'b11: begin
        grant0_s = ~prio_r;
        grant1_s = prio_r;
      end
      default: begin
        grant0_s = 1'b0;
        grant1_s = 1'b0;
      end
    endcase
  end

  assign req0_ready = ~buf0_full_r | grant0_s;
  assign req1_ready = ~buf1_full_r | grant1_s;
  assign acc0_s     = req0_valid & req0_ready;
  assign acc1_s     = req1_valid & req1_ready;

  // Write-port mux; everything is held at zero when no buffer is granted
  always_comb begin
    if (grant0_s) begin
      rf_wr_enable = 1'b1;
      rf_wr_addr   = buf0_addr_r;
      rf_wr_data   = buf0_data_r;
    end else if (grant1_s) begin
      rf_wr_enable = 1'b1;
      rf_wr_addr   = buf1_addr_r;
      rf_wr_data   = buf1_data_r;
    end else begin
      rf_wr_enable = 1'b0;
      rf_wr_addr   = {AW{1'b0}};
      rf_wr_data   = {DATA_BUS_WIDTH{1'b0}};
    end
  end

  // Bit 0 is forced low as x0 is never buffered
  always_comb begin
    pend_mask = {NUM_OF_SETS{1'b0}};
    if (buf0_full_r) begin
      pend_mask = pend_mask | onehot(buf0_addr_r);
    end else begin
      pend_mask = pend_mask;
    end
    if (buf1_full_r) begin
      pend_mask = pend_mask | onehot(buf1_addr_r);
    end else begin
      pend_mask = pend_mask;
    end
    pend_mask[0] = 1'b0;
  end

  // Buffer load/drain and round-robin pointer update
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf0_full_r <= 1'b0;
      buf1_full_r <= 1'b0;
      buf0_addr_r <= {AW{1'b0}};
      buf1_addr_r <= {AW{1'b0}};
      buf0_data_r <= {DATA_BUS_WIDTH{1'b0}};
      buf1_data_r <= {DATA_BUS_WIDTH{1'b0}};
      prio_r      <= 1'b0;
    end else begin
      if (acc0_s) begin
        // An accepted write to x0 completes the handshake but never occupies the buffer
        buf0_full_r <= (req0_addr != {AW{1'b0}});
        buf0_addr_r <= req0_addr;
        buf0_data_r <= req0_data;
      end else if (grant0_s) begin
        buf0_full_r <= 1'b0;
      end
      if (acc1_s) begin
        buf1_full_r <= (req1_addr != {AW{1'b0}});
        buf1_addr_r <= req1_addr;
        buf1_data_r <= req1_data;
      end else if (grant1_s) begin
        buf1_full_r <= 1'b0;
      end
      if (grant0_s) begin
        prio_r <= 1'b1;
      end else if (grant1_s) begin
        prio_r <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rv32i_regfile_write_arbiter.sv
// Scoreboard bench: a per-cycle reference model predicts commits into a queue,
// and an independent monitor checks every write-port cycle against it.
module tb_rv32i_regfile_write_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic [4:0]  req0_addr = 5'd0, req1_addr = 5'd0;
  logic [31:0] req0_data = 32'd0, req1_data = 32'd0;
  logic        req0_ready, req1_ready;
  logic        rf_wr_enable;
  logic [4:0]  rf_wr_addr;
  logic [31:0] rf_wr_data;
  logic [31:0] pend_mask;

  int checks = 0;
  int failures = 0;

  logic [36:0] exp_q[$];
  logic [36:0] mon_e;

  // Reference model: each requester holds at most one pending write
  bit          m_full[2];
  logic [4:0]  m_addr[2];
  logic [31:0] m_data[2];
  int          m_prio;

  rv32i_regfile_write_arbiter dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(req1_ready),
    .rf_wr_enable(rf_wr_enable), .rf_wr_addr(rf_wr_addr), .rf_wr_data(rf_wr_data),
    .pend_mask(pend_mask)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Called at the negedge: predict this cycle's outputs, then the state after the next edge
  task automatic model_eval();
    int g;
    bit rdy[2];
    logic [31:0] pend;
    logic        v[2];
    logic [4:0]  a[2];
    logic [31:0] d[2];
    v[0] = req0_valid; a[0] = req0_addr; d[0] = req0_data;
    v[1] = req1_valid; a[1] = req1_addr; d[1] = req1_data;
    if (m_full[0] && m_full[1]) g = m_prio;
    else if (m_full[0]) g = 0;
    else if (m_full[1]) g = 1;
    else g = -1;
    pend = 32'd0;
    for (int i = 0; i < 2; i++) begin
      rdy[i] = !m_full[i] || (g == i);
      if (m_full[i]) pend[m_addr[i]] = 1'b1;
    end
    check("req0_ready", {63'd0, req0_ready}, {63'd0, rdy[0]});
    check("req1_ready", {63'd0, req1_ready}, {63'd0, rdy[1]});
    check("pend_mask", {32'd0, pend_mask}, {32'd0, pend});
    if (g >= 0) begin
      exp_q.push_back({m_addr[g], m_data[g]});
      m_full[g] = 1'b0;
      m_prio = (g == 0) ? 1 : 0;
    end
    for (int i = 0; i < 2; i++) begin
      if (v[i] && rdy[i] && a[i] != 5'd0) begin
        m_full[i] = 1'b1;
        m_addr[i] = a[i];
        m_data[i] = d[i];
      end
    end
  endtask

  // Entered and left at posedge+1
  task automatic step(input logic v0, input logic [4:0] a0, input logic [31:0] d0,
                      input logic v1, input logic [4:0] a1, input logic [31:0] d1);
    req0_valid = v0; req0_addr = a0; req0_data = d0;
    req1_valid = v1; req1_addr = a1; req1_data = d1;
    @(negedge clk);
    model_eval();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
  endtask

  // Monitor: every cycle the write port must match the head of the expected queue
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (rf_wr_enable) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_write: got addr=%0d data=%0h expected no write", rf_wr_addr, rf_wr_data);
        end else begin
          mon_e = exp_q.pop_front();
          check("wr_addr", {59'd0, rf_wr_addr}, {59'd0, mon_e[36:32]});
          check("wr_data", {32'd0, rf_wr_data}, {32'd0, mon_e[31:0]});
        end
      end else begin
        checks++;
        if (exp_q.size() != 0) begin
          mon_e = exp_q.pop_front();
          failures++;
          $display("FAIL missing_write: got none expected addr=%0d data=%0h", mon_e[36:32], mon_e[31:0]);
        end
        check("idle_port_zero", {27'd0, rf_wr_addr, rf_wr_data}, 64'd0);
      end
    end
  end

  initial begin
    m_full[0] = 1'b0; m_full[1] = 1'b0; m_prio = 0;
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    check("rst_enable", {63'd0, rf_wr_enable}, 64'd0);
    check("rst_ready", {62'd0, req1_ready, req0_ready}, 64'd3);
    check("rst_pend", {32'd0, pend_mask}, 64'd0);
    rst = 1'b0;

    // Contention from prio=0: x3 then x4
    step(1'b1, 5'd3, 32'h11, 1'b1, 5'd4, 32'h22);
    idle(3);
    // Single write
    step(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0);
    idle(2);
    // Round-robin with both requesters valid every cycle
    for (int i = 0; i < 6; i++)
      step(1'b1, 5'(i + 1), 32'(32'hA000 + i), 1'b1, 5'(i + 10), 32'(32'hB000 + i));
    idle(3);
    // x0 drop
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hFFFFFFFF);
    idle(2);
    // Streaming on requester 1
    for (int i = 1; i <= 8; i++)
      step(1'b0, 5'd0, 32'd0, 1'b1, 5'(i), 32'(32'hC0 + i));
    idle(2);
    // Randomized traffic, with x0 destinations mixed in
    for (int i = 0; i < 400; i++) begin
      logic [4:0] ra0, ra1;
      ra0 = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      ra1 = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      step(1'($urandom_range(0, 1)), ra0, $urandom, 1'($urandom_range(0, 1)), ra1, $urandom);
    end
    idle(3);

    // Fill both buffers, then reset mid-cycle
    step(1'b1, 5'd7, 32'h77, 1'b1, 5'd9, 32'h99);
    #2 rst = 1'b1;
    #1;
    check("midrst_enable", {63'd0, rf_wr_enable}, 64'd0);
    check("midrst_port", {27'd0, rf_wr_addr, rf_wr_data}, 64'd0);
    check("midrst_ready", {62'd0, req1_ready, req0_ready}, 64'd3);
    check("midrst_pend", {32'd0, pend_mask}, 64'd0);
    m_full[0] = 1'b0; m_full[1] = 1'b0; m_prio = 0;
    exp_q.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    idle(4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
